// File: rtl/spi_reg_slave.sv
// spi_reg_slave: SPI slave bridging a command/address word protocol onto a
// simple register fabric port. Word 0 of each CS frame is {rw, ..., addr};
// following words are register writes (rw=0) or reads (rw=1).
// All four SPI modes (CPOL/CPHA) and any DATA_W >= ADDR_W+1 are supported.
// Build option: define SPI_REG_AUTOINC_EN to step the address after every
// data word (burst access); otherwise one register is streamed.
`timescale 1ns/1ps
module spi_reg_slave #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4,
  parameter int CPOL   = 0,
  parameter int CPHA   = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sclk,
  input  logic              cs,
  input  logic              mosi,
  output logic              miso,
  output logic              miso_oe,
  output logic              reg_wr_en,
  output logic [ADDR_W-1:0] reg_wr_addr,
  output logic [DATA_W-1:0] reg_wr_data,
  output logic              reg_rd_en,
  output logic [ADDR_W-1:0] reg_rd_addr,
  input  logic [DATA_W-1:0] reg_rd_data,
  output logic              frame_active,
  output logic              frame_done,
  output logic              frame_abort
);

  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  typedef enum logic [1:0] {IDLE, CMD, WRITE, READ} state_t;

  state_t              state_q, state_d;
  logic [2:0]          sclk_sync_q, sclk_sync_d;
  logic [2:0]          cs_sync_q, cs_sync_d;
  logic [1:0]          mosi_sync_q, mosi_sync_d;
  logic [CNT_W-1:0]    bit_cnt_q, bit_cnt_d;
  logic [DATA_W-1:0]   shift_q, shift_d;
  logic [DATA_W-1:0]   tx_q, tx_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                rd_pend_q, rd_pend_d;
  logic                miso_q, miso_d;
  logic                reg_wr_en_q, reg_wr_en_d;
  logic [ADDR_W-1:0]   reg_wr_addr_q, reg_wr_addr_d;
  logic [DATA_W-1:0]   reg_wr_data_q, reg_wr_data_d;
  logic                reg_rd_en_q, reg_rd_en_d;
  logic [ADDR_W-1:0]   reg_rd_addr_q, reg_rd_addr_d;
  logic                frame_active_q, frame_active_d;
  logic                frame_done_q, frame_done_d;
  logic                frame_abort_q, frame_abort_d;

  // Edge and level decode on the synchronised copies.
  logic              sclk_rise, sclk_fall, lead_edge, trail_edge;
  logic              sample_edge, drive_edge, cs_fall, cs_high, last_bit;
  logic [DATA_W-1:0] shift_next;
  logic [ADDR_W-1:0] addr_next;

  assign sclk_rise   = sclk_sync_q[1] & ~sclk_sync_q[2];
  assign sclk_fall   = ~sclk_sync_q[1] & sclk_sync_q[2];
  assign lead_edge   = (CPOL == 0) ? sclk_rise : sclk_fall;
  assign trail_edge  = (CPOL == 0) ? sclk_fall : sclk_rise;
  assign sample_edge = (CPHA == 0) ? lead_edge : trail_edge;
  assign drive_edge  = (CPHA == 0) ? trail_edge : lead_edge;
  assign cs_fall     = ~cs_sync_q[1] & cs_sync_q[2];
  assign cs_high     = cs_sync_q[1];
  assign shift_next  = {shift_q[DATA_W-2:0], mosi_sync_q[1]};
  assign last_bit    = (bit_cnt_q == CNT_W'(DATA_W - 1));

`ifdef SPI_REG_AUTOINC_EN
  assign addr_next = addr_q + ADDR_W'(1);
`else
  assign addr_next = addr_q;
`endif

  // Next-state logic: synchronisers, frame FSM, shift registers and strobes.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
    sclk_sync_d    = {sclk_sync_q[1:0], sclk};
    cs_sync_d      = {cs_sync_q[1:0], cs};
    mosi_sync_d    = {mosi_sync_q[0], mosi};
    state_d        = state_q;
    bit_cnt_d      = bit_cnt_q;
    shift_d        = shift_q;
    tx_d           = tx_q;
    addr_d         = addr_q;
    rd_pend_d      = reg_rd_en_q;
    miso_d         = miso_q;
    reg_wr_en_d    = 1'b0;
    reg_wr_addr_d  = reg_wr_addr_q;
    reg_wr_data_d  = reg_wr_data_q;
    reg_rd_en_d    = 1'b0;
    reg_rd_addr_d  = reg_rd_addr_q;
    frame_active_d = frame_active_q;
    frame_done_d   = 1'b0;
    frame_abort_d  = 1'b0;

    // Fabric data arrives the clk after the read request.
    if (rd_pend_q) tx_d = reg_rd_data;

    case (state_q)
      IDLE: begin
        miso_d = 1'b0;
        if (cs_fall) begin
          state_d        = CMD;
          bit_cnt_d      = '0;
          frame_active_d = 1'b1;
        end
      end
      default: begin
        if (cs_high) begin
          // CS release wins over any edge in the same clk; a partial word is dropped.
          state_d        = IDLE;
          frame_active_d = 1'b0;
          frame_done_d   = 1'b1;
          frame_abort_d  = (bit_cnt_q != '0);
          bit_cnt_d      = '0;
          miso_d         = 1'b0;
        end else begin
          if (sample_edge) begin
            shift_d   = shift_next;
            bit_cnt_d = last_bit ? '0 : bit_cnt_q + CNT_W'(1);
            if (last_bit) begin
              case (state_q)
                CMD: begin
                  addr_d = shift_next[ADDR_W-1:0];
                  if (shift_next[DATA_W-1]) begin
                    reg_rd_en_d   = 1'b1;
                    reg_rd_addr_d = shift_next[ADDR_W-1:0];
                    state_d       = READ;
                  end else begin
                    state_d = WRITE;
                  end
                end
                WRITE: begin
                  reg_wr_en_d   = 1'b1;
                  reg_wr_addr_d = addr_q;
                  reg_wr_data_d = shift_next;
                  addr_d        = addr_next;
                end
                READ: begin
                  reg_rd_en_d   = 1'b1;
                  reg_rd_addr_d = addr_next;
                  addr_d        = addr_next;
                end
                default: ;
              endcase
            end
          end
          if (drive_edge && (state_q == READ)) begin
            miso_d = tx_q[DATA_W-1];
            tx_d   = {tx_q[DATA_W-2:0], 1'b0};
          end
        end
      end
    endcase
  end

  // State register; CS sync resets to "asserted" so a CS held low through
  // reset produces no falling edge and cannot start a frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sclk_sync_q    <= '0;
      cs_sync_q      <= '0;
      mosi_sync_q    <= '0;
      state_q        <= IDLE;
      bit_cnt_q      <= '0;
      shift_q        <= '0;
      tx_q           <= '0;
      addr_q         <= '0;
      rd_pend_q      <= 1'b0;
      miso_q         <= 1'b0;
      reg_wr_en_q    <= 1'b0;
      reg_wr_addr_q  <= '0;
      reg_wr_data_q  <= '0;
      reg_rd_en_q    <= 1'b0;
      reg_rd_addr_q  <= '0;
      frame_active_q <= 1'b0;
      frame_done_q   <= 1'b0;
      frame_abort_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking so every flop samples the pre-edge values.
      sclk_sync_q    <= sclk_sync_d;
      cs_sync_q      <= cs_sync_d;
      mosi_sync_q    <= mosi_sync_d;
      state_q        <= state_d;
      bit_cnt_q      <= bit_cnt_d;
      shift_q        <= shift_d;
      tx_q           <= tx_d;
      addr_q         <= addr_d;
      rd_pend_q      <= rd_pend_d;
      miso_q         <= miso_d;
      reg_wr_en_q    <= reg_wr_en_d;
      reg_wr_addr_q  <= reg_wr_addr_d;
      reg_wr_data_q  <= reg_wr_data_d;
      reg_rd_en_q    <= reg_rd_en_d;
      reg_rd_addr_q  <= reg_rd_addr_d;
      frame_active_q <= frame_active_d;
      frame_done_q   <= frame_done_d;
      frame_abort_q  <= frame_abort_d;
    end
  end

  assign miso         = miso_q;
  assign miso_oe      = frame_active_q;
  assign reg_wr_en    = reg_wr_en_q;
  assign reg_wr_addr  = reg_wr_addr_q;
  assign reg_wr_data  = reg_wr_data_q;
  assign reg_rd_en    = reg_rd_en_q;
  assign reg_rd_addr  = reg_rd_addr_q;
  assign frame_active = frame_active_q;
  assign frame_done   = frame_done_q;
  assign frame_abort  = frame_abort_q;

endmodule

// File: tb/tb_spi_reg_slave.sv
// tb_spi_reg_slave: four spi_reg_slave instances, one per SPI mode, each with
// its own register fabric. A bit-banged master drives one instance per frame;
// a word-level reference model predicts writes, read requests, MISO words and
// frame_done/frame_abort pulses.
`timescale 1ns/1ps
module tb_spi_reg_slave;

  localparam int T = 60;  // SCLK half period (clk is 10 ns)
`ifdef SPI_REG_AUTOINC_EN
  localparam int INC = 1;
`else
  localparam int INC = 0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic fab_clr = 1'b1;
  logic [3:0] sclk_r = 4'b1100;
  logic [3:0] cs_r   = 4'b1111;
  logic [3:0] mosi_r = 4'b0000;
  logic [3:0] miso_w, oe_w, wr_en_w, rd_en_w, fa_w, fd_w, fab_w;
  logic [3:0][3:0] wr_addr_w, rd_addr_w;
  logic [3:0][7:0] wr_data_w, rd_data_w;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    spi_reg_slave #(.DATA_W(8), .ADDR_W(4), .CPOL(g / 2), .CPHA(g % 2)) u_dut (
      .clk(clk), .rst(rst), .sclk(sclk_r[g]), .cs(cs_r[g]), .mosi(mosi_r[g]),
      .miso(miso_w[g]), .miso_oe(oe_w[g]),
      .reg_wr_en(wr_en_w[g]), .reg_wr_addr(wr_addr_w[g]), .reg_wr_data(wr_data_w[g]),
      .reg_rd_en(rd_en_w[g]), .reg_rd_addr(rd_addr_w[g]), .reg_rd_data(rd_data_w[g]),
      .frame_active(fa_w[g]), .frame_done(fd_w[g]), .frame_abort(fab_w[g])
    );
  end

  // Register fabric: one 16-entry bank per instance, read data one clk after request.
  logic [7:0] fab_mem [4][16];
  always @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (fab_clr) begin
        for (int j = 0; j < 16; j++) fab_mem[i][j] <= 8'(8'h40 + j);
      end else if (wr_en_w[i]) begin
        fab_mem[i][wr_addr_w[i]] <= wr_data_w[i];
      end
      if (rd_en_w[i]) rd_data_w[i] <= fab_mem[i][rd_addr_w[i]];
    end
  end

  // Monitor, sampled on the falling clk edge.
  int cur = 0;
  logic [11:0] got_wr[$];
  logic [3:0]  got_rd[$];
  int done_cnt = 0, abort_cnt = 0, lone_abort = 0, stray = 0;
  always @(negedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 4; i++) begin
        if (i == cur) begin
          if (wr_en_w[i]) got_wr.push_back({wr_addr_w[i], wr_data_w[i]});
          if (rd_en_w[i]) got_rd.push_back(rd_addr_w[i]);
          if (fd_w[i]) done_cnt++;
          if (fab_w[i]) abort_cnt++;
          if (fab_w[i] && !fd_w[i]) lone_abort++;
        end else if (wr_en_w[i] || rd_en_w[i] || fd_w[i] || fab_w[i]) begin
          stray++;
        end
      end
    end
  end

  int n_tests = 0, n_fail = 0;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: word-level view of one frame.
  logic [7:0]  model_mem [4][16];
  logic [11:0] exp_wr[$];
  logic [3:0]  exp_rd[$];
  logic [7:0]  exp_rx [4];
  int          exp_abort;

  task automatic model_frame(input int m, input int n, input logic [7:0] w [4], input int partial);
    int a;
    exp_wr.delete();
    exp_rd.delete();
    for (int k = 0; k < 4; k++) exp_rx[k] = 8'h00;
    if (n > 0) begin
      a = int'(w[0] % 16);
      if (w[0] >= 8'h80) begin
        exp_rd.push_back(4'(a));
        for (int k = 1; k < n; k++) begin
          exp_rx[k] = model_mem[m][a];
          a = (a + INC) % 16;
          exp_rd.push_back(4'(a));
        end
      end else begin
        for (int k = 1; k < n; k++) begin
          exp_wr.push_back({4'(a), w[k]});
          model_mem[m][a] = w[k];
          a = (a + INC) % 16;
        end
      end
    end
    exp_abort = (partial > 0) ? 1 : 0;
  endtask

  // One SPI bit slot for instance m: mosi b out, miso sampled into r.
  task automatic spi_bit(input int m, input logic b, output logic r);
    logic cpol, cpha;
    cpol = (m / 2) == 1;
    cpha = (m % 2) == 1;
    r = 1'b0;
    if (!cpha) mosi_r[m] = b;
    #T;
    sclk_r[m] = ~cpol;
    if (!cpha) r = miso_w[m];
    else mosi_r[m] = b;
    #T;
    sclk_r[m] = cpol;
    if (cpha) r = miso_w[m];
  endtask

  task automatic clear_mon(input int m);
    cur = m;
    got_wr.delete();
    got_rd.delete();
    done_cnt = 0;
    abort_cnt = 0;
    lone_abort = 0;
  endtask

  // Full frame: n complete words then `partial` bits of pval, compared to the model.
  task automatic do_frame(input string tag, input int m, input int n,
                          input logic [7:0] w0, input logic [7:0] w1,
                          input logic [7:0] w2, input logic [7:0] w3,
                          input int partial, input logic [7:0] pval);
    logic [7:0] w [4];
    logic [7:0] rx [4];
    logic r;
    w[0] = w0; w[1] = w1; w[2] = w2; w[3] = w3;
    model_frame(m, n, w, partial);
    clear_mon(m);
    cs_r[m] = 1'b0;
    for (int k = 0; k < n; k++) begin
      rx[k] = 8'h00;
      for (int b = 7; b >= 0; b--) begin
        spi_bit(m, w[k][b], r);
        rx[k] = {rx[k][6:0], r};
        if (k == 0 && b == 7) begin
          check({tag, ":oe"}, 32'(oe_w[m]), 32'd1);
          check({tag, ":active"}, 32'(fa_w[m]), 32'd1);
        end
      end
    end
    for (int p = 0; p < partial; p++) spi_bit(m, pval[7 - p], r);
    #T;
    cs_r[m] = 1'b1;
    #200;
    check({tag, ":wr_cnt"}, 32'(got_wr.size()), 32'(exp_wr.size()));
    for (int i = 0; i < got_wr.size() && i < exp_wr.size(); i++)
      check({tag, ":wr"}, 32'(got_wr[i]), 32'(exp_wr[i]));
    check({tag, ":rd_cnt"}, 32'(got_rd.size()), 32'(exp_rd.size()));
    for (int i = 0; i < got_rd.size() && i < exp_rd.size(); i++)
      check({tag, ":rd_addr"}, 32'(got_rd[i]), 32'(exp_rd[i]));
    for (int k = 0; k < n; k++) check({tag, ":miso"}, 32'(rx[k]), 32'(exp_rx[k]));
    check({tag, ":done"}, 32'(done_cnt), 32'd1);
    check({tag, ":abort"}, 32'(abort_cnt), 32'(exp_abort));
    check({tag, ":abort_alone"}, 32'(lone_abort), 32'd0);
    check({tag, ":idle_oe"}, 32'(oe_w[m]), 32'd0);
  endtask

  initial begin
    logic r;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 16; j++) model_mem[i][j] = 8'(8'h40 + j);

    // Reset state
    #22;
    check("rst:miso", 32'(miso_w), 32'd0);
    check("rst:oe", 32'(oe_w), 32'd0);
    check("rst:strobes", 32'({wr_en_w, rd_en_w}), 32'd0);
    check("rst:frame", 32'({fa_w, fd_w, fab_w}), 32'd0);
    #3;
    rst = 1'b0;
    fab_clr = 1'b0;
    #100;

    // Mode 0 directed: burst write, read with wrap, streamed read
    do_frame("m0_wr", 0, 3, 8'h03, 8'hA5, 8'h5A, 8'h00, 0, 8'h00);
    do_frame("m0_rd", 0, 3, 8'h8E, 8'h00, 8'h00, 8'h00, 0, 8'h00);
    do_frame("m0_rd5", 0, 4, 8'h85, 8'h00, 8'h00, 8'h00, 0, 8'h00);

    // Modes 1..3: write then read back
    for (int m = 1; m < 4; m++) begin
      do_frame("mx_wr", m, 2, 8'h01, 8'hC3, 8'h00, 8'h00, 0, 8'h00);
      do_frame("mx_rd", m, 2, 8'h81, 8'h00, 8'h00, 8'h00, 0, 8'h00);
    end

    // Abort mid-word, then a clean frame; zero-edge frame
    do_frame("abort", 0, 1, 8'h02, 8'h00, 8'h00, 8'h00, 5, 8'hB8);
    do_frame("post_abort", 0, 2, 8'h02, 8'h77, 8'h00, 8'h00, 0, 8'h00);
    do_frame("empty", 1, 0, 8'h00, 8'h00, 8'h00, 8'h00, 0, 8'h00);

    // Async reset in the middle of a read word
    do_frame("rst_prep", 0, 2, 8'h07, 8'hFF, 8'h00, 8'h00, 0, 8'h00);
    clear_mon(0);
    cs_r[0] = 1'b0;
    for (int b = 7; b >= 0; b--) spi_bit(0, 1'(8'h87 >> b), r);
    for (int b = 0; b < 3; b++) spi_bit(0, 1'b0, r);
    check("rst_mid:miso_before", 32'(miso_w[0]), 32'd1);
    #17;
    rst = 1'b1;
    #1;
    check("rst_mid:miso", 32'(miso_w), 32'd0);
    check("rst_mid:oe", 32'(oe_w), 32'd0);
    check("rst_mid:strobes", 32'({wr_en_w, rd_en_w, fd_w, fab_w}), 32'd0);
    #40;
    rst = 1'b0;
    clear_mon(0);
    for (int b = 0; b < 16; b++) spi_bit(0, 1'(b % 2), r);
    check("rst_hold:active", 32'(fa_w[0]), 32'd0);
    check("rst_hold:wr", 32'(got_wr.size()), 32'd0);
    check("rst_hold:rd", 32'(got_rd.size()), 32'd0);
    cs_r[0] = 1'b1;
    #200;
    check("rst_hold:done", 32'(done_cnt), 32'd0);
    do_frame("rst_after", 0, 2, 8'h87, 8'h00, 8'h00, 8'h00, 0, 8'h00);

    // Randomized frames
    for (int t = 0; t < 30; t++) begin
      int m, n, partial;
      logic [7:0] c;
      m = int'($urandom_range(0, 3));
      n = int'($urandom_range(0, 4));
      partial = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 7)) : 0;
      c = 8'($urandom);
      do_frame("rand", m, n, c, 8'($urandom), 8'($urandom), 8'($urandom),
               partial, 8'($urandom));
    end

    check("stray", 32'(stray), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
